// File: rtl/spi_reg_bus_master_if.sv
`timescale 1ns/1ps
// SPI pins and internal register bus seen by spi_reg_bus_master.
// The master modport is the block's view; slave is the pins/register-block side.
interface spi_reg_bus_master_if;
  logic        spiSclk;
  logic        spiSsN;
  logic        spiMosi;
  logic        spiMiso;
  logic        spiMisoOe;
  logic        cs;
  logic        wr0;
  logic        wr1;
  logic        wr2;
  logic        wr3;
  logic [12:0] addr;
  logic [31:0] busDataOut;
  logic [31:0] busDataIn;
  logic        busy;
  logic        frameErr;

  modport master (
    input  spiSclk, spiSsN, spiMosi, busDataIn,
    output spiMiso, spiMisoOe, cs, wr0, wr1, wr2, wr3, addr, busDataOut, busy, frameErr
  );

  modport slave (
    output spiSclk, spiSsN, spiMosi, busDataIn,
    input  spiMiso, spiMisoOe, cs, wr0, wr1, wr2, wr3, addr, busDataOut, busy, frameErr
  );
endinterface

// File: rtl/spi_reg_bus_master.sv
`timescale 1ns/1ps
// SPI mode-0 slave that turns framed host commands into byte-strobed register
// writes or captured register reads on the internal demod register bus.
module spi_reg_bus_master #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_SETTLE   = 2
) (
  input  logic                 busClk,
  input  logic                 nReset,
  spi_reg_bus_master_if.master bus
);

  localparam int STARTUP = SYNC_STAGES + 1;
  localparam int SUW     = $clog2(STARTUP + 1);
  localparam int STW     = $clog2(RD_SETTLE + 1);
  localparam logic [SUW-1:0] STARTUP_END = SUW'(STARTUP);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(RD_SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HEADER    = 3'd1,
    WR_DATA   = 3'd2,
    RD_ACCESS = 3'd3,
    RD_DATA   = 3'd4,
    DONE      = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sclkSync_r;
  logic [SYNC_STAGES-1:0] ssSync_r;
  logic [SYNC_STAGES-1:0] mosiSync_r;
  logic                   sclkPrev_r;
  logic                   ssPrev_r;
  logic [SUW-1:0]         startCnt_r;

  state_t         state_r;
  state_t         nextState_s;
  logic [5:0]     bitCnt_r;
  logic [5:0]     bitCnt_s;
  logic [31:0]    shift_r;
  logic [31:0]    shift_s;
  logic [STW-1:0] settle_r;
  logic [STW-1:0] settle_s;

  logic        cs_r;
  logic        cs_s;
  logic [3:0]  wr_r;
  logic [3:0]  wr_s;
  logic [12:0] addr_r;
  logic [12:0] addr_s;
  logic [31:0] dataOut_r;
  logic [31:0] dataOut_s;
  logic        miso_r;
  logic        miso_s;
  logic        misoOe_r;
  logic        misoOe_s;
  logic        busy_r;
  logic        busy_s;
  logic        frameErr_r;
  logic        frameErr_s;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic sample_s;
  logic shiftEv_s;
  logic ssFall_s;
  logic ssRise_s;
  logic startup_s;

  assign sclk_s    = sclkSync_r[SYNC_STAGES-1];
  assign ss_s      = ssSync_r[SYNC_STAGES-1];
  assign mosi_s    = mosiSync_r[SYNC_STAGES-1];
  assign sample_s  = sclk_s & ~sclkPrev_r;
  assign shiftEv_s = ~sclk_s & sclkPrev_r;
  assign ssFall_s  = ~ss_s & ssPrev_r;
  assign ssRise_s  = ss_s & ~ssPrev_r;
  // Until the select synchronizer has flushed its reset value, a low select
  // means the frame started before reset was released and must be skipped.
  assign startup_s = (startCnt_r != STARTUP_END);

  // Synchronize the SPI pins and keep previous values for edge detection.
  always_ff @(posedge busClk or negedge nReset) begin
    if (!nReset) begin
      sclkSync_r <= {SYNC_STAGES{1'b0}};
      ssSync_r   <= {SYNC_STAGES{1'b1}};
      mosiSync_r <= {SYNC_STAGES{1'b0}};
      sclkPrev_r <= 1'b0;
      ssPrev_r   <= 1'b1;
    end else begin
      sclkSync_r <= {sclkSync_r[SYNC_STAGES-2:0], bus.spiSclk};
      ssSync_r   <= {ssSync_r[SYNC_STAGES-2:0], bus.spiSsN};
      mosiSync_r <= {mosiSync_r[SYNC_STAGES-2:0], bus.spiMosi};
      sclkPrev_r <= sclk_s;
      ssPrev_r   <= ss_s;
    end
  end

  // Post-reset window counter covering the synchronizer flush.
  always_ff @(posedge busClk or negedge nReset) begin
    if (!nReset) begin
      startCnt_r <= {SUW{1'b0}};
    end else if (startup_s) begin
      startCnt_r <= startCnt_r + SUW'(1);
    end else begin
      startCnt_r <= startCnt_r;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    nextState_s = state_r;
    bitCnt_s    = bitCnt_r;
    shift_s     = shift_r;
    settle_s    = settle_r;
    cs_s        = 1'b0;
    wr_s        = 4'b0000;
    addr_s      = addr_r;
    dataOut_s   = dataOut_r;
    miso_s      = miso_r;
    misoOe_s    = ~ss_s;
    busy_s      = busy_r;
    frameErr_s  = 1'b0;

    case (state_r)
      IDLE: begin
        miso_s = 1'b0;
        if (startup_s) begin
          if (!ss_s) begin
            nextState_s = DONE;
          end else begin
            nextState_s = IDLE;
          end
        end else if (ssFall_s) begin
          nextState_s = HEADER;
          bitCnt_s    = 6'd0;
          shift_s     = 32'd0;
          busy_s      = 1'b1;
        end else begin
          nextState_s = IDLE;
        end
      end

      HEADER: begin
        if (sample_s) begin
          shift_s  = {shift_r[30:0], mosi_s};
          bitCnt_s = bitCnt_r + 6'd1;
          if (bitCnt_r == 6'd15) begin
            addr_s   = {shift_r[11:0], mosi_s};
            bitCnt_s = 6'd0;
            if (shift_r[14]) begin
              nextState_s = RD_ACCESS;
              cs_s        = 1'b1;
              settle_s    = {STW{1'b0}};
            end else begin
              nextState_s = WR_DATA;
            end
          end else begin
            nextState_s = HEADER;
          end
        end else begin
          nextState_s = HEADER;
        end
      end

      WR_DATA: begin
        if (sample_s) begin
          shift_s  = {shift_r[30:0], mosi_s};
          bitCnt_s = bitCnt_r + 6'd1;
          if (bitCnt_r[2:0] == 3'b111) begin
            cs_s = 1'b1;
            // First data byte on the wire is the most significant lane.
            case (bitCnt_r[4:3])
              2'd0: begin
                wr_s             = 4'b1000;
                dataOut_s[31:24] = {shift_r[6:0], mosi_s};
              end
              2'd1: begin
                wr_s             = 4'b0100;
                dataOut_s[23:16] = {shift_r[6:0], mosi_s};
              end
              2'd2: begin
                wr_s            = 4'b0010;
                dataOut_s[15:8] = {shift_r[6:0], mosi_s};
              end
              2'd3: begin
                wr_s           = 4'b0001;
                dataOut_s[7:0] = {shift_r[6:0], mosi_s};
              end
              default: begin
                wr_s = 4'b0000;
              end
            endcase
            if (bitCnt_r[4:3] == 2'd3) begin
              nextState_s = DONE;
            end else begin
              nextState_s = WR_DATA;
            end
          end else begin
            nextState_s = WR_DATA;
          end
        end else begin
          nextState_s = WR_DATA;
        end
      end

      RD_ACCESS: begin
        if (settle_r == SETTLE_LAST) begin
          cs_s        = 1'b0;
          shift_s     = bus.busDataIn;
          miso_s      = bus.busDataIn[31];
          bitCnt_s    = 6'd0;
          nextState_s = RD_DATA;
        end else begin
          cs_s     = 1'b1;
          settle_s = settle_r + STW'(1);
        end
      end

      RD_DATA: begin
        if (sample_s) begin
          bitCnt_s = bitCnt_r + 6'd1;
          if (bitCnt_r == 6'd31) begin
            nextState_s = DONE;
            miso_s      = 1'b0;
          end else begin
            nextState_s = RD_DATA;
          end
        end else if (shiftEv_s && (bitCnt_r != 6'd0)) begin
          // Bit 31 was presented at capture; advance only once the host has sampled it.
          shift_s = {shift_r[30:0], 1'b0};
          miso_s  = shift_r[30];
        end else begin
          nextState_s = RD_DATA;
        end
      end

      DONE: begin
        miso_s = 1'b0;
      end

      default: begin
        nextState_s = IDLE;
        miso_s      = 1'b0;
      end
    endcase

    // A deselect ends any frame; a byte completed in the same cycle still strobes.
    if (ssRise_s && (state_r != IDLE)) begin
      nextState_s = IDLE;
      busy_s      = 1'b0;
      miso_s      = 1'b0;
      cs_s        = |wr_s;
      frameErr_s  = (state_r == HEADER) && !(sample_s && (bitCnt_r == 6'd15));
    end else begin
      frameErr_s = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge busClk or negedge nReset) begin
    if (!nReset) begin
      state_r    <= IDLE;
      bitCnt_r   <= 6'd0;
      shift_r    <= 32'd0;
      settle_r   <= {STW{1'b0}};
      cs_r       <= 1'b0;
      wr_r       <= 4'b0000;
      addr_r     <= 13'd0;
      dataOut_r  <= 32'd0;
      miso_r     <= 1'b0;
      misoOe_r   <= 1'b0;
      busy_r     <= 1'b0;
      frameErr_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      bitCnt_r   <= bitCnt_s;
      shift_r    <= shift_s;
      settle_r   <= settle_s;
      cs_r       <= cs_s;
      wr_r       <= wr_s;
      addr_r     <= addr_s;
      dataOut_r  <= dataOut_s;
      miso_r     <= miso_s;
      misoOe_r   <= misoOe_s;
      busy_r     <= busy_s;
      frameErr_r <= frameErr_s;
    end
  end

  assign bus.cs         = cs_r;
  assign bus.wr0        = wr_r[0];
  assign bus.wr1        = wr_r[1];
  assign bus.wr2        = wr_r[2];
  assign bus.wr3        = wr_r[3];
  assign bus.addr       = addr_r;
  assign bus.busDataOut = dataOut_r;
  assign bus.spiMiso    = miso_r;
  assign bus.spiMisoOe  = misoOe_r;
  assign bus.busy       = busy_r;
  assign bus.frameErr   = frameErr_r;

endmodule

// File: tb/tb_spi_reg_bus_master.sv
`timescale 1ns/1ps
// Bench for spi_reg_bus_master: table of SPI frames, strobe scoreboard,
// and a hand-written reset-during-read sequence.
module tb_spi_reg_bus_master;

  localparam int SYNC_STAGES = 2;
  localparam int RD_SETTLE   = 2;
  localparam int HALF        = 100;

  logic busClk = 1'b0;
  logic nReset = 1'b0;

  always #5 busClk = ~busClk;

  spi_reg_bus_master_if bus ();

  spi_reg_bus_master #(
    .SYNC_STAGES(SYNC_STAGES),
    .RD_SETTLE  (RD_SETTLE)
  ) dut (
    .busClk(busClk),
    .nReset(nReset),
    .bus   (bus)
  );

  // Register-block read model.
  function automatic logic [31:0] rdModel(input logic [12:0] a);
    if (a == 13'h0044) return 32'h0000_0013;
    return {a, 19'h0} ^ 32'h0005_A5A5;
  endfunction

  assign bus.busDataIn = bus.cs ? rdModel(bus.addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic [1:0]  lane;
    logic [12:0] addr;
    logic [7:0]  data;
  } strobe_t;

  typedef struct {
    logic        rd;
    logic [12:0] addr;
    logic [31:0] data;
    int          nBits;
    int          expFerr;
    logic [31:0] expOut;
  } vec_t;

  strobe_t sbQ[$];
  vec_t    vecs[8];
  int      vecCnt = 0;
  int      errCnt = 0;
  int      csOnlyCnt = 0;
  int      ferrCnt = 0;
  logic [3:0] wrV;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Bus monitor: pop expected strobes, count cs-only cycles and frameErr cycles.
  always @(negedge busClk) begin
    if (nReset) begin
      wrV = {bus.wr3, bus.wr2, bus.wr1, bus.wr0};
      if (bus.frameErr) ferrCnt++;
      if (bus.cs && (wrV == 4'b0000)) csOnlyCnt++;
      if (wrV != 4'b0000) begin
        if (sbQ.size() == 0) begin
          check("unexpected_strobe", {60'd0, wrV}, 64'd0);
        end else begin
          strobe_t e;
          e = sbQ.pop_front();
          check("strobe_lane", {60'd0, wrV}, 64'd1 << e.lane);
          check("strobe_cs", {63'd0, bus.cs}, 64'd1);
          check("strobe_addr", {51'd0, bus.addr}, {51'd0, e.addr});
          check("strobe_data", {56'd0, 8'(bus.busDataOut >> (8 * e.lane))}, {56'd0, e.data});
        end
      end
    end
  end

  task automatic spiFrame(input logic rd, input logic [12:0] a, input logic [31:0] d,
                          input int nBits, output logic [31:0] misoW);
    logic [15:0] hdr;
    strobe_t     s;
    int          lane;
    hdr   = {rd, 2'b00, a};
    misoW = 32'd0;
    bus.spiSsN = 1'b0;
    #(HALF);
    for (int i = 0; i < nBits; i++) begin
      if (i < 16)      bus.spiMosi = hdr[15-i];
      else if (i < 48) bus.spiMosi = d[47-i];
      else             bus.spiMosi = 1'b1;
      #(HALF);
      if (i >= 16 && i < 48) misoW = {misoW[30:0], bus.spiMiso};
      bus.spiSclk = 1'b1;
      if (!rd && i >= 16 && i < 48 && ((i - 16) % 8) == 7) begin
        lane   = 3 - (i - 16) / 8;
        s.lane = 2'(lane);
        s.addr = a;
        s.data = 8'(d >> (8 * lane));
        sbQ.push_back(s);
      end
      if (i == 3) check("busy_mid_frame", {63'd0, bus.busy}, 64'd1);
      #(HALF);
      bus.spiSclk = 1'b0;
    end
    #(HALF);
    bus.spiSsN  = 1'b1;
    bus.spiMosi = 1'b0;
    #(300);
  endtask

  task automatic spiBit(input logic b);
    bus.spiMosi = b;
    #(HALF);
    bus.spiSclk = 1'b1;
    #(HALF);
    bus.spiSclk = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] hdr;
    int          k;

    bus.spiSclk = 1'b0;
    bus.spiSsN  = 1'b1;
    bus.spiMosi = 1'b0;

    vecs[0] = '{1'b0, 13'h0040, 32'hA5C3_1E07, 48, 0, 32'hA5C3_1E07};
    vecs[1] = '{1'b1, 13'h0044, 32'h0000_0000, 48, 0, 32'hA5C3_1E07};
    vecs[2] = '{1'b0, 13'h0100, 32'h1234_5678, 36, 0, 32'h1234_1E07};
    vecs[3] = '{1'b0, 13'h0ABC, 32'h5555_5555, 10, 1, 32'h1234_1E07};
    vecs[4] = '{1'b0, 13'h0001, 32'hFFFF_FFFF, 48, 0, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 13'h0002, 32'h0F0E_0D0C, 56, 0, 32'h0F0E_0D0C};
    vecs[6] = '{1'b1, 13'h1FFF, 32'h0000_0000, 48, 0, 32'h0F0E_0D0C};
    vecs[7] = '{1'b1, 13'h0123, 32'h0000_0000, 24, 0, 32'h0F0E_0D0C};

    #23;
    check("reset_outputs",
          {bus.cs, bus.wr3, bus.wr2, bus.wr1, bus.wr0, bus.addr, bus.busDataOut,
           bus.spiMiso, bus.spiMisoOe, bus.busy, bus.frameErr}, 64'd0);
    nReset = 1'b1;
    #200;

    for (int v = 0; v < 8; v++) begin
      csOnlyCnt = 0;
      ferrCnt   = 0;
      spiFrame(vecs[v].rd, vecs[v].addr, vecs[v].data, vecs[v].nBits, w);
      check($sformatf("v%0d_strobes_left", v), 64'(sbQ.size()), 64'd0);
      check($sformatf("v%0d_frameErr", v), 64'(ferrCnt), 64'(vecs[v].expFerr));
      check($sformatf("v%0d_cs_only", v), 64'(csOnlyCnt),
            (vecs[v].rd && vecs[v].nBits >= 16) ? 64'(RD_SETTLE) : 64'd0);
      check($sformatf("v%0d_busy_end", v), {63'd0, bus.busy}, 64'd0);
      check($sformatf("v%0d_miso_end", v), {63'd0, bus.spiMiso}, 64'd0);
      check($sformatf("v%0d_dataOut", v), {32'd0, bus.busDataOut}, {32'd0, vecs[v].expOut});
      k = vecs[v].nBits - 16;
      if (k > 32) k = 32;
      if (vecs[v].rd && k > 0)
        check($sformatf("v%0d_miso_word", v), {32'd0, w}, {32'd0, rdModel(vecs[v].addr) >> (32 - k)});
    end

    // Reset in the middle of a read, released while the select is still low.
    hdr = 16'h8044;
    bus.spiSsN = 1'b0;
    #(HALF);
    for (int i = 0; i < 16; i++) spiBit(hdr[15-i]);
    for (int i = 0; i < 4; i++) spiBit(1'b0);
    #(HALF / 2);
    nReset = 1'b0;
    #1;
    check("midread_reset_outputs",
          {bus.cs, bus.wr3, bus.wr2, bus.wr1, bus.wr0, bus.addr, bus.busDataOut,
           bus.spiMiso, bus.spiMisoOe, bus.busy, bus.frameErr}, 64'd0);
    #50;
    csOnlyCnt = 0;
    ferrCnt   = 0;
    nReset    = 1'b1;
    #200;
    for (int i = 0; i < 8; i++) spiBit(1'(i % 2));
    #100;
    check("postrst_cs_only", 64'(csOnlyCnt), 64'd0);
    check("postrst_busy", {63'd0, bus.busy}, 64'd0);
    check("postrst_miso", {63'd0, bus.spiMiso}, 64'd0);
    check("postrst_misoOe", {63'd0, bus.spiMisoOe}, 64'd1);
    check("postrst_addr", {51'd0, bus.addr}, 64'd0);
    bus.spiSsN = 1'b1;
    #300;
    check("postrst_frameErr", 64'(ferrCnt), 64'd0);
    check("postrst_misoOe_off", {63'd0, bus.spiMisoOe}, 64'd0);

    csOnlyCnt = 0;
    spiFrame(1'b1, 13'h0044, 32'd0, 48, w);
    check("postrst_read_word", {32'd0, w}, 64'h0000_0013);
    check("postrst_read_cs", 64'(csOnlyCnt), 64'(RD_SETTLE));
    check("postrst_read_busy", {63'd0, bus.busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/spi_reg_bus_master.md
Name: spi_reg_bus_master

Overview:
- SPI slave front end that acts as initiator on the internal demod register bus (cs, wr0..wr3, addr[12:0], 32-bit write/read data).
- An external host or micro issues framed read/write commands over SPI. The block turns each command into byte-strobed register writes, or into a combinational register read that is captured and shifted back out.
- Sits between the board SPI pins and the register-block bus fan-out, including demod, bitsync and despreader register blocks. It is the sole driver of that bus.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on spiSclk, spiSsN and spiMosi (minimum 2).
- RD_SETTLE, 2, busClk cycles cs/addr are held before read data is captured (minimum 1).

Ports:
- busClk  input  1  system/bus clock; all logic is synchronous to it.
- nReset  input  1  asynchronous active-low reset.
- spiSclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to busClk.
- spiSsN  input  1  SPI select, active-low, frames one command.
- spiMosi  input  1  serial data from host, MSB first.
- spiMiso  output  1  serial read data to host.
- spiMisoOe  output  1  MISO output enable; high only while spiSsN is low.
- cs  output  1  register bus chip select.
- wr0, wr1, wr2, wr3  output  1 each  byte-lane write strobes for bits [7:0], [15:8], [23:16], [31:24].
- addr  output  13  register bus address.
- busDataOut  output  32  write data to register blocks.
- busDataIn  input  32  read data from the muxed register blocks, combinational in addr/cs.
- busy  output  1  high from frame start until return to IDLE.
- frameErr  output  1  one-cycle pulse when a frame is aborted during the header.

Behaviour:
- Reset values (nReset low, asynchronous):
  - 0: cs, wr0..wr3, addr, busDataOut, spiMiso, spiMisoOe, busy, frameErr.
  - State = IDLE.
- SPI inputs pass through SYNC_STAGES flops.
- Edge detect on synchronized spiSclk: a rise is a sample event, a fall is a shift event.
- spiSclk frequency must not exceed busClk/(2*(SYNC_STAGES+RD_SETTLE+3)).
- Frame format, MSB first:
  - 16-bit header: bit15 = read (1) / write (0); bits14:13 ignored; bits12:0 = addr.
  - Followed by up to 32 data bits.
- State IDLE:
  - Falling edge of synchronized spiSsN -> HEADER; bit counter cleared, busy=1.
- State HEADER:
  - Shift spiMosi in on each sample event.
  - On the 16th sample: latch addr.
  - If read -> RD_ACCESS; else -> WR_DATA.
- State WR_DATA:
  - Bytes are taken from the data bits.
  - 1st data byte -> lane 3 (busDataOut[31:24]), 2nd -> lane 2, 3rd -> lane 1, 4th -> lane 0.
  - When a byte completes, in the cycle after its 8th sample event: busDataOut lane loaded and held; cs=1 and that lane's wrN=1 for exactly one busClk cycle.
  - Other lanes of busDataOut keep their prior values.
  - After the 4th byte -> DONE.
- State RD_ACCESS:
  - cs=1 with addr stable for RD_SETTLE cycles.
  - On the last cycle, capture busDataIn into the 32-bit shift register, then cs=0.
  - spiMiso = bit31, driven before the next shift event; then -> RD_DATA.
  - No wrN asserted.
- State RD_DATA:
  - On each shift event after the 16th sample, spiMiso advances to the next lower bit.
  - After 32 data bits -> DONE; spiMiso=0 thereafter.
- State DONE:
  - Ignore all SCLK activity: no further writes, spiMiso=0. There is no address auto-increment.
- spiSsN rise, from any state:
  - In HEADER (<16 bits): frameErr pulses for 1 cycle; no bus access occurs.
  - In WR_DATA: complete bytes are already written; a partial trailing byte is discarded with no strobe.
  - In RD_ACCESS/RD_DATA: the read ends quietly.
  - In all cases -> IDLE, busy=0, spiMiso=0.
- spiMisoOe = synchronized ~spiSsN.
- A strobe and an spiSsN rise in the same cycle: the strobe for the completed byte still issues.
- Reset released while spiSsN is low: go to DONE, not HEADER. The block waits for spiSsN high before accepting a frame.
- cs is never high outside write-strobe cycles and RD_ACCESS.
- wr0..wr3 are mutually exclusive.

Test Plan:
- Write addr 0x0040, data 0xA5C3_1E07 (48 SCLKs) -> four single-cycle strobes in order: wr3 (busDataOut[31:24]=A5), wr2 (C3), wr1 (1E), wr0 (07). Each has cs=1 and addr=0x0040; busDataOut ends at 0xA5C31E07.
- Read addr 0x0044 with busDataIn model returning 0x0000_0013 -> cs high for RD_SETTLE cycles, no wrN; MISO returns 0x00000013 on the 32 data bits.
- Write frame ended after 20 data bits (SsN rises mid 3rd byte) -> only wr3 and wr2 pulse; no wr1/wr0; busy drops.
- SsN rises after 10 header bits -> frameErr single pulse; cs and wrN never assert; next complete write of 0xFFFFFFFF to 0x0001 succeeds.
- 56-SCLK write frame -> exactly four strobes; the extra 8 bits cause no bus activity.
- nReset asserted mid-read and released with SsN low -> all outputs 0, no cs; SCLK ignored until SsN high; the following frame works normally.
